// File: rtl/md6_bram_target.sv
// BRAM-port responder for the MD6 control engine: CTRL/STATUS/RESULT/SCRATCH
// registers plus a command FIFO feeding the engine, with one-cycle read latency.
module md6_bram_target #(
  parameter int FIFO_LOG2  = 3,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_WIDTH-1:0] bramAddr,
  input  logic [31:0]           bramDout,
  input  logic [3:0]            bramWEN,
  input  logic                  bramEN,
  output logic [31:0]           bramDin,
  output logic                  start_pulse,
  output logic                  cmd_valid,
  output logic [31:0]           cmd_data,
  input  logic                  cmd_ready,
  input  logic                  done_in,
  input  logic [31:0]           result_in
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]    FULL_CNT = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_STAT   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_PUSH   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_RES    = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_SCR    = ADDR_WIDTH'(4);

  logic [31:0]          din_q, din_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          result_q, result_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]   count_q, count_d;
  logic [31:0]          mem_q [DEPTH];

  logic        wr, start_req, flush, w1c_done, w1c_ovf, push;
  logic        full, empty, pop, do_push, ovf_set;
  logic [31:0] status, rdata;

  assign wr        = bramEN && (bramWEN != 4'h0);
  assign start_req = wr && (bramAddr == A_CTRL) && bramWEN[0] && bramDout[0];
  assign flush     = wr && (bramAddr == A_CTRL) && bramWEN[0] && bramDout[1];
  assign w1c_done  = wr && (bramAddr == A_STAT) && bramWEN[0] && bramDout[1];
  assign w1c_ovf   = wr && (bramAddr == A_STAT) && bramWEN[0] && bramDout[2];
  assign push      = wr && (bramAddr == A_PUSH) && (bramWEN == 4'hF);

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop     = cmd_valid && cmd_ready;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  assign status = {16'h0, 8'(count_q), 3'b0, empty, full, ovf_q, done_q, busy_q};

  always_comb begin
    rdata = 32'h0;
    case (bramAddr)
      A_STAT:  rdata = status;
      A_RES:   rdata = result_q;
      A_SCR:   rdata = scratch_q;
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    din_d     = bramEN ? rdata : din_q;
    start_d   = start_req;
    busy_d    = start_req | (busy_q & ~done_in);
    done_d    = done_in | (done_q & ~w1c_done);
    ovf_d     = ovf_set | (ovf_q & ~w1c_ovf);
    result_d  = done_in ? result_in : result_q;
    scratch_d = scratch_q;
    for (int i = 0; i < 4; i++)
      if (wr && (bramAddr == A_SCR) && bramWEN[i])
        scratch_d[8*i +: 8] = bramDout[8*i +: 8];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + FIFO_LOG2'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
      case ({do_push, pop})
        2'b10:   count_d = count_q + (FIFO_LOG2+1)'(1);
        2'b01:   count_d = count_q - (FIFO_LOG2+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      din_q     <= 32'h0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= 32'h0;
      scratch_q <= 32'h0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      din_q     <= din_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      scratch_q <= scratch_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge CLK) begin
    if (!flush && do_push) mem_q[wr_ptr_q] <= bramDout;
  end

  assign bramDin     = din_q;
  assign start_pulse = start_q;
  assign cmd_valid   = !empty;
  assign cmd_data    = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_md6_bram_target.sv
// Directed bench for md6_bram_target: queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_md6_bram_target;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [13:0] bramAddr = '0;
  logic [31:0] bramDout = '0;
  logic [3:0]  bramWEN = '0;
  logic        bramEN = 1'b0;
  logic [31:0] bramDin;
  logic        start_pulse, cmd_valid, cmd_ready = 1'b0, done_in = 1'b0;
  logic [31:0] cmd_data, result_in = '0;

  int tests = 0, fails = 0;

  md6_bram_target #(.FIFO_LOG2(3), .ADDR_WIDTH(14)) dut (
    .CLK(CLK), .RST_N(RST_N), .bramAddr(bramAddr), .bramDout(bramDout),
    .bramWEN(bramWEN), .bramEN(bramEN), .bramDin(bramDin),
    .start_pulse(start_pulse), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .done_in(done_in), .result_in(result_in)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: registers as plain variables, FIFO as a queue of depth 8.
  logic [31:0] m_din = 0, m_result = 0, m_scratch = 0;
  bit          m_start = 0, m_busy = 0, m_done = 0, m_ovf = 0;
  logic [31:0] m_q[$];

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    return (n << 8) | ((n == 0) << 4) | ((n == 8) << 3) | (m_ovf << 2) | (m_done << 1) | m_busy;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_din = 0; m_result = 0; m_scratch = 0;
      m_start = 0; m_busy = 0; m_done = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      bit wr, st, fl, popq;
      int n0;
      wr = bramEN && (bramWEN != 0);
      if (bramEN)
        case (bramAddr)
          1: m_din = m_status();
          3: m_din = m_result;
          4: m_din = m_scratch;
          default: m_din = 0;
        endcase
      st = wr && bramAddr == 0 && bramWEN[0] && bramDout[0];
      fl = wr && bramAddr == 0 && bramWEN[0] && bramDout[1];
      n0 = m_q.size();
      popq = (n0 > 0) && cmd_ready;
      if (fl) m_q.delete();
      else begin
        if (popq) void'(m_q.pop_front());
        if (wr && bramAddr == 2 && bramWEN == 4'hF) begin
          if (n0 == 8 && !popq) m_ovf = 1;
          else m_q.push_back(bramDout);
        end
      end
      if (wr && bramAddr == 1 && bramWEN[0]) begin
        if (bramDout[1] && !done_in) m_done = 0;
        if (bramDout[2] && !(n0 == 8 && !popq && bramAddr == 2)) m_ovf = 0;
      end
      if (done_in) begin m_done = 1; m_result = result_in; end
      if (st) m_busy = 1; else if (done_in) m_busy = 0;
      for (int i = 0; i < 4; i++)
        if (wr && bramAddr == 4 && bramWEN[i]) m_scratch[8*i +: 8] = bramDout[8*i +: 8];
      m_start = st;
    end
  end

  always @(negedge CLK) begin
    check("bramDin", bramDin, m_din);
    check("start_pulse", 32'(start_pulse), 32'(m_start));
    check("cmd_valid", 32'(cmd_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("cmd_data", cmd_data, m_q[0]);
  end

  logic [31:0] pop_log[$];
  always @(posedge CLK)
    if (RST_N && cmd_valid && cmd_ready) pop_log.push_back(cmd_data);

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] w);
    bramEN = 1; bramAddr = 14'(a); bramDout = d; bramWEN = w;
    @(posedge CLK); #1;
    bramEN = 0; bramWEN = 0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string name);
    bramEN = 1; bramAddr = 14'(a); bramWEN = 0;
    @(posedge CLK); #1;
    bramEN = 0;
    check(name, bramDin, exp);
  endtask

  initial begin
    idle(3);
    RST_N = 1;
    idle(1);
    rd(1, 32'h0000_0010, "status_after_reset");

    wr(4, 32'hDEADBEEF, 4'hF);
    wr(4, 32'h11223344, 4'b0101);
    rd(4, 32'hDE22BE44, "scratch_lanes");
    bramAddr = 4; bramWEN = 4'hF; bramDout = 0; idle(1); bramWEN = 0;
    rd(4, 32'hDE22BE44, "scratch_en_low");
    wr(7, 32'hFFFFFFFF, 4'hF);
    rd(7, 32'h0, "unmapped_read");

    for (int i = 1; i <= 9; i++) wr(2, 32'(i), 4'hF);
    rd(1, 32'h0000_080C, "status_full_ovf");
    wr(2, 32'h55, 4'h7);
    wr(1, 32'h4, 4'h1);
    rd(1, 32'h0000_0808, "status_full");
    pop_log.delete();
    cmd_ready = 1; idle(10); cmd_ready = 0;
    check("pop_count", 32'(pop_log.size()), 8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) check("pop_order", pop_log[i], 32'(i + 1));
    check("valid_after_drain", 32'(cmd_valid), 0);

    for (int i = 2; i <= 9; i++) wr(2, 32'(i), 4'hF);
    pop_log.delete();
    cmd_ready = 1; wr(2, 32'd10, 4'hF); cmd_ready = 0;
    rd(1, 32'h0000_0808, "status_push_pop_full");
    cmd_ready = 1; idle(10); cmd_ready = 0;
    check("pop_count2", 32'(pop_log.size()), 9);
    if (pop_log.size() > 0) check("last_pop", pop_log[pop_log.size()-1], 32'd10);

    wr(0, 32'h1, 4'h1);
    check("start_pulse_hi", 32'(start_pulse), 1);
    idle(1);
    check("start_pulse_lo", 32'(start_pulse), 0);
    rd(1, 32'h0000_0011, "status_busy");
    done_in = 1; result_in = 32'hCAFE0001; idle(1); done_in = 0;
    rd(3, 32'hCAFE0001, "result");
    rd(1, 32'h0000_0012, "status_done");
    wr(1, 32'h2, 4'h1);
    rd(1, 32'h0000_0010, "status_w1c");
    wr(0, 32'h1, 4'h2);
    wr(0, 32'h1, 4'h1); wr(0, 32'h1, 4'h1);
    done_in = 1; result_in = 32'h12345678; wr(0, 32'h1, 4'h1); done_in = 0;
    rd(1, 32'h0000_0013, "status_start_done");
    done_in = 1; wr(1, 32'h2, 4'h1); done_in = 0;
    rd(1, 32'h0000_0012, "status_done_w1c_same");
    wr(1, 32'h2, 4'h1);
    rd(1, 32'h0000_0010, "status_clear");

    wr(2, 32'hA1, 4'hF);
    wr(0, 32'h2, 4'h1);
    wr(2, 32'hB1, 4'hF);
    wr(2, 32'hB2, 4'hF);
    rd(1, 32'h0000_0200, "status_after_flush_push");
    cmd_ready = 1; wr(0, 32'h2, 4'h1); cmd_ready = 0;
    rd(1, 32'h0000_0010, "status_flush_pop");
    check("valid_after_flush", 32'(cmd_valid), 0);

    for (int i = 0; i < 3; i++) wr(2, 32'(i + 100), 4'hF);
    bramEN = 1; bramAddr = 4; bramWEN = 0;
    @(posedge CLK); #1;
    check("read_before_reset", bramDin, 32'hDE22BE44);
    #1 RST_N = 0;
    #1;
    check("reset_din", bramDin, 0);
    check("reset_valid", 32'(cmd_valid), 0);
    bramEN = 0;
    idle(2);
    RST_N = 1;
    idle(1);
    rd(1, 32'h0000_0010, "status_after_mid_reset");
    rd(4, 32'h0, "scratch_after_reset");
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md6_bram_target.md
# md6_bram_target

Memory-mapped BRAM-port responder that terminates the MD6 control engine's 32-bit BRAM initiator interface. It decodes word addresses into a small control/status register bank and a command FIFO, and returns read data with one-cycle latency. On the core side it issues a start pulse and queued command words to the MD6 engine, and captures the engine's done flag and result word.

## Interface
Parameters:
- FIFO_LOG2, 3, log2 of command FIFO depth (depth 8)
- ADDR_WIDTH, 14, word-address width of the BRAM port

Ports:
- CLK  in  1  sole clock; all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- bramAddr  in  ADDR_WIDTH  word address (byte address >> 2)
- bramDout  in  32  write data from initiator
- bramWEN  in  4  byte write enables; bit i covers bits [8i+7:8i]
- bramEN  in  1  access strobe; a read when bramWEN==0
- bramDin  out  32  registered read data
- start_pulse  out  1  one-cycle start request to MD6 engine
- cmd_valid  out  1  FIFO head valid
- cmd_data  out  32  FIFO head word
- cmd_ready  in  1  engine pops head when cmd_valid && cmd_ready
- done_in  in  1  one-cycle completion pulse from engine
- result_in  in  32  result word, sampled when done_in=1

## Operation
Register map (word address; all other addresses read 0, writes ignored):
- 0 CTRL (W): bit0=1 -> start_pulse next cycle; bit1=1 -> flush FIFO. Acts when any WEN bit set and that bit's byte lane is enabled. Reads 0.
- 1 STATUS (R/W1C): bit0 busy, bit1 done (sticky), bit2 overflow (sticky), bit3 FIFO full, bit4 FIFO empty, bits[15:8] FIFO count. Writing 1 to bit1/bit2 with WEN[0]=1 clears it.
- 2 CMD_PUSH (W): pushes bramDout only when bramWEN==4'hF; partial writes ignored. Reads 0.
- 3 RESULT (R): last result_in latched on done_in.
- 4 SCRATCH (R/W): per-byte-lane write.
- Access occurs only when bramEN=1; bramEN=0 -> no state change, bramDin holds.
- busy: set by start; cleared by done_in. Start and done_in in the same cycle -> busy stays 1, done set.
- done sticky: set by done_in; done_in and W1C in the same cycle -> done stays 1.
- FIFO: circular buffer with FIFO_LOG2-bit pointers that wrap, plus a (FIFO_LOG2+1)-bit count.
  - Push when full with no same-cycle pop -> word dropped, overflow set.
  - Push and pop in the same cycle when full -> both occur, count unchanged.
  - Pop when empty is impossible because cmd_valid=0.
  - Flush wins over a same-cycle push or pop: count=0, pointers=0.
- Reset values: bramDin=0, start_pulse=0, cmd_valid=0, cmd_data=don't-care, busy=0, done=0, overflow=0, RESULT=0, SCRATCH=0, FIFO empty.
- Reset asserted mid-transaction discards the access and FIFO contents immediately (asynchronous).

## Timing
- Read: bramEN=1, WEN=0 in cycle N -> bramDin valid in cycle N+1 and held until the next access.
- Write: register updates at the edge ending cycle N; a read in N+1 sees the new value.
- A write access in cycle N also loads bramDin with the pre-write value of the addressed register.
- STATUS count/flags seen by a read in cycle N reflect state before that cycle's push/pop.
- start_pulse is high for exactly one cycle (N+1) per CTRL write; back-to-back writes give back-to-back pulses.
- cmd_valid rises the cycle after the first push into an empty FIFO; cmd_data comes from the head register, with no bypass.
- Throughput: one BRAM access per cycle, no stalls; the responder never back-pressures.

## Test plan
- Reset: RST_N=0 mid-read -> bramDin=0, STATUS reads 0x0000_0010, cmd_valid=0.
- Scratch byte lanes: write 0xDEADBEEF WEN=F, then write 0x11223344 WEN=4'b0101 -> read addr 4 returns 0xDE22BE44 one cycle after EN.
- FIFO fill/overflow: with cmd_ready=0, push 9 words 1..9 -> STATUS=0x0000_080C (count 8, full, overflow); raise cmd_ready -> cmd_data pops 1..8 in order, cmd_valid drops after 8.
- Simultaneous push/pop at full: push 10 while popping -> count stays 8, no overflow; last popped word = 10.
- Start/done: write CTRL=1 -> start_pulse high one cycle, busy=1; done_in with result_in=0xCAFE0001 -> RESULT=0xCAFE0001, STATUS bit1=1, bit0=0; W1C 0x2 -> done cleared.
- Flush vs push: CTRL bit1 and CMD_PUSH on adjacent cycles, then flush asserted in the same cycle as a pop -> FIFO empty, count 0, cmd_valid=0.
